// File: rtl/usb_bulk_in_pkt_fifo.sv
// Packetising bulk-IN FIFO: cuts the user stream into USB packets and holds each one until ACKed.
// Optional idle-flush of partial packets is enabled by defining USB_BULK_IN_FLUSH_EN.
module usb_bulk_in_pkt_fifo #(
  parameter int ADDR_WIDTH   = 11,
  parameter int MAX_PACKET   = 512,
  parameter int FLUSH_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  input  logic                  s_tlast_i,
  input  logic [7:0]            s_tdata_i,
  output logic                  has_data_o,
  input  logic                  rd_req_i,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tlast_o,
  output logic [7:0]            m_tdata_o,
  input  logic                  ack_i,
  input  logic                  retry_i,
  output logic [ADDR_WIDTH:0]   pkt_count_o,
  output logic [ADDR_WIDTH:0]   free_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int CW    = (MAX_PACKET > 1) ? $clog2(MAX_PACKET) : 1;

  if ((ADDR_WIDTH < CW + 1) || (FLUSH_CYCLES < 1)) begin : g_param_check
    $error("usb_bulk_in_pkt_fifo: ADDR_WIDTH too small for MAX_PACKET or FLUSH_CYCLES < 1");
  end

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_e;

  state_e          state_q, state_d;
  logic [8:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q, cmt_ptr_q;
  logic [CW-1:0]   pcnt_q;
  logic [PW-1:0]   pkt_count_q, pkt_count_d;
  logic            has_data_q;
  logic [PW-1:0]   used;
  logic            wr_hs, eop_w, pkt_inc, flush;
  logic            issue, ack_take, rewind, pop, arr_last;
  logic [1:0]      occ;
  logic            eop_seen_q;
  logic            vld_p1_q;
  logic [8:0]      rdata_p1_q;
  logic            out_vld_q, out_last_q;
  logic [7:0]      out_data_q;
  logic            skid_vld_q, skid_last_q;
  logic [7:0]      skid_data_q;

  // Occupancy is measured against the committed pointer so unACKed bytes are never overwritten.
  assign used       = wr_ptr_q - cmt_ptr_q;
  assign free_o     = PW'(DEPTH) - used;
  assign s_tready_o = (free_o != '0) && !reset;
  assign wr_hs      = s_tvalid_i && s_tready_o;
  assign eop_w      = s_tlast_i || (pcnt_q == CW'(MAX_PACKET - 1));
  assign pkt_inc    = (wr_hs && eop_w) || flush;

  always_ff @(posedge clock) begin
    if (wr_hs) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {eop_w, s_tdata_i};
    if (issue) rdata_p1_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  end

`ifdef USB_BULK_IN_FLUSH_EN
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  logic [FW-1:0] idle_q;
  logic          flag_mem [DEPTH];
  logic          flag_p1_q;
  logic [PW-1:0] last_wr_ptr;

  assign last_wr_ptr = wr_ptr_q - PW'(1);
  assign flush    = (idle_q == FW'(FLUSH_CYCLES)) && (pcnt_q != '0) && !wr_hs && !reset;
  assign arr_last = rdata_p1_q[8] | flag_p1_q;

  always_ff @(posedge clock) begin
    if (reset || wr_hs || flush) idle_q <= '0;
    else if ((pcnt_q != '0) && !s_tvalid_i && (idle_q != FW'(FLUSH_CYCLES))) idle_q <= idle_q + FW'(1);
  end

  // Every write clears its late-EOP flag, so stale flags never outlive a rewrite.
  always_ff @(posedge clock) begin
    if (wr_hs) flag_mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= 1'b0;
    else if (flush) flag_mem[last_wr_ptr[ADDR_WIDTH-1:0]] <= 1'b1;
    if (issue) flag_p1_q <= flag_mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  end
`else
  assign flush    = 1'b0;
  assign arr_last = rdata_p1_q[8];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      pcnt_q   <= '0;
    end else if (wr_hs) begin
      wr_ptr_q <= wr_ptr_q + PW'(1);
      pcnt_q   <= eop_w ? '0 : pcnt_q + CW'(1);
    end else if (flush) begin
      pcnt_q   <= '0;
    end
  end

  assign pop = out_vld_q && m_tready_i;
  assign occ = {1'b0, out_vld_q && !pop} + {1'b0, skid_vld_q} + {1'b0, vld_p1_q};

  // Fetch only while the next RAM word is sure to find room; never fetch past the EOP byte.
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    ack_take = 1'b0;
    rewind   = 1'b0;
    case (state_q)
      IDLE: if (rd_req_i && (pkt_count_q != '0)) state_d = SEND;
      SEND: begin
        if (retry_i) begin
          rewind  = 1'b1;
          state_d = IDLE;
        end else begin
          issue = !eop_seen_q && !(vld_p1_q && arr_last) && (occ <= 2'd1);
          if (pop && out_last_q) state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_i) begin
          ack_take = 1'b1;
          state_d  = IDLE;
        end else if (retry_i) begin
          rewind  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pkt_count_d = pkt_count_q + PW'(pkt_inc) - PW'(ack_take);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      cmt_ptr_q   <= '0;
      pkt_count_q <= '0;
      has_data_q  <= 1'b0;
      eop_seen_q  <= 1'b0;
      vld_p1_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_count_q <= pkt_count_d;
      has_data_q  <= (pkt_count_d != '0);
      if (rewind) rd_ptr_q <= cmt_ptr_q;
      else if (issue) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (ack_take) cmt_ptr_q <= rd_ptr_q;
      if (state_q != SEND) eop_seen_q <= 1'b0;
      else if (vld_p1_q && arr_last) eop_seen_q <= 1'b1;
      vld_p1_q <= issue && !rewind;
    end
  end

  // Output register plus one-entry skid: holds data stable while the sink stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
      skid_vld_q <= 1'b0;
    end else if (rewind) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_vld_q  <= 1'b1;
        out_last_q <= skid_last_q;
        out_data_q <= skid_data_q;
        skid_vld_q <= vld_p1_q;
      end else begin
        out_vld_q <= vld_p1_q;
        if (vld_p1_q) begin
          out_last_q <= arr_last;
          out_data_q <= rdata_p1_q[7:0];
        end
      end
    end else if (vld_p1_q) begin
      skid_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (vld_p1_q && ((out_vld_q && !pop) || skid_vld_q)) begin
      skid_last_q <= arr_last;
      skid_data_q <= rdata_p1_q[7:0];
    end
  end

  assign has_data_o  = has_data_q;
  assign pkt_count_o = pkt_count_q;
  assign m_tvalid_o  = out_vld_q;
  assign m_tlast_o   = out_last_q;
  assign m_tdata_o   = out_data_q;

endmodule

// File: tb/tb_usb_bulk_in_pkt_fifo.sv
// Directed bench for usb_bulk_in_pkt_fifo with a byte scoreboard of {eop,data} entries.
module tb_usb_bulk_in_pkt_fifo;
  localparam int AW = 11, MP = 512, FC = 16, DEPTH = 2048;

  logic clock = 1'b0, reset = 1'b1;
  logic s_tvalid_i = 1'b0, s_tlast_i = 1'b0, rd_req_i = 1'b0, m_tready_i = 1'b0;
  logic ack_i = 1'b0, retry_i = 1'b0;
  logic [7:0] s_tdata_i = '0;
  logic s_tready_o, has_data_o, m_tvalid_o, m_tlast_o;
  logic [7:0] m_tdata_o;
  logic [AW:0] pkt_count_o, free_o;

  always #5 clock = ~clock;

  usb_bulk_in_pkt_fifo #(.ADDR_WIDTH(AW), .MAX_PACKET(MP), .FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset(reset),
    .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tlast_i(s_tlast_i), .s_tdata_i(s_tdata_i),
    .has_data_o(has_data_o), .rd_req_i(rd_req_i),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o), .m_tdata_o(m_tdata_o),
    .ack_i(ack_i), .retry_i(retry_i), .pkt_count_o(pkt_count_o), .free_o(free_o)
  );

  int compared = 0, mismatched = 0;
  logic [8:0] exp_q[$];
  int mpcnt = 0, mpkts = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    compared++;
    mismatched++;
    $error("FAIL %s: observed=timeout expected=completion", tag);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pkts"}, 32'(pkt_count_o), 32'(mpkts));
    check({tag, "_hasd"}, 32'(has_data_o), 32'(mpkts != 0));
    check({tag, "_free"}, 32'(free_o), 32'(DEPTH - exp_q.size()));
  endtask

  task automatic model_push(input logic [7:0] d, input logic l);
    logic eop;
    eop = l || (mpcnt == MP - 1);
    exp_q.push_back({eop, d});
    if (eop) begin mpcnt = 0; mpkts++; end
    else mpcnt++;
  endtask

  function automatic int head_len();
    for (int k = 0; k < exp_q.size(); k++) if (exp_q[k][8]) return k + 1;
    return 0;
  endfunction

  task automatic model_ack();
    int n;
    n = head_len();
    for (int k = 0; k < n; k++) void'(exp_q.pop_front());
    mpkts--;
  endtask

  task automatic write_bytes(input int n, input bit last_end);
    int guard;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom_range(0, 255));
      s_tvalid_i = 1'b1; s_tdata_i = d; s_tlast_i = last_end && (i == n - 1);
      guard = 0;
      while (!s_tready_o && guard < 4000) begin tick(); guard++; end
      if (guard >= 4000) begin timeout_fail("wr_ready"); break; end
      model_push(d, s_tlast_i);
      tick();
    end
    s_tvalid_i = 1'b0; s_tlast_i = 1'b0;
  endtask

  // mode: 0 ack, 1 retry, 2 leave in WAIT_ACK, 3 ack+retry together
  task automatic read_pkt(input int mode, input bit stall);
    int explen, j, cyc, first;
    bit done, hold;
    logic [8:0] held, expv;
    explen = head_len();
    rd_req_i = 1'b1; j = 0; cyc = 0; first = -1; done = 0; hold = 0; held = '0;
    while (!done && cyc < 3000) begin
      if (m_tvalid_o && first < 0) first = cyc;
      if (hold) check("stall_stable", {22'd0, m_tvalid_o, m_tlast_o, m_tdata_o}, {22'd0, 1'b1, held});
      m_tready_i = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (m_tvalid_o && m_tready_i) begin
        expv = (j < exp_q.size()) ? exp_q[j] : 9'h000;
        check("rd_byte", {23'd0, m_tlast_o, m_tdata_o}, {23'd0, expv});
        if (m_tlast_o) done = 1;
        j++;
      end
      hold = m_tvalid_o && !m_tready_i;
      held = {m_tlast_o, m_tdata_o};
      tick();
      cyc++;
    end
    rd_req_i = 1'b0; m_tready_i = 1'b0;
    if (!done) timeout_fail("rd_done");
    check("vld_lat", 32'(first >= 0 && first <= 3), 32'd1);
    check("pkt_len", 32'(j), 32'(explen));
    if (mode == 0 || mode == 3) begin
      ack_i = 1'b1; retry_i = (mode == 3);
      tick();
      ack_i = 1'b0; retry_i = 1'b0;
      model_ack();
      check_state("ack");
    end else if (mode == 1) begin
      retry_i = 1'b1;
      tick();
      retry_i = 1'b0;
      check_state("retry");
    end
  endtask

  initial begin
    int n;
    // reset values
    tick(); tick();
    check("rst_rdy", 32'(s_tready_o), 32'd0);
    check("rst_vld", 32'(m_tvalid_o), 32'd0);
    check("rst_last", 32'(m_tlast_o), 32'd0);
    check("rst_data", 32'(m_tdata_o), 32'd0);
    check_state("rst");
    reset = 1'b0;
    #1;
    check("rdy_after_rst", 32'(s_tready_o), 32'd1);

    // 100-byte packet
    write_bytes(99, 0);
    check_state("p99");
    write_bytes(1, 1);
    check_state("p100");
    read_pkt(0, 0);

    // 1100 bytes without tlast, then reset mid-packet
    write_bytes(1100, 0);
    check_state("p1100");
    check("pend76", 32'(mpcnt), 32'd76);
    reset = 1'b1;
    tick();
    check("midrst_rdy", 32'(s_tready_o), 32'd0);
    reset = 1'b0;
    #1;
    exp_q.delete(); mpcnt = 0; mpkts = 0;
    check_state("midrst");

    // ack ignored in IDLE, abort in SEND, retry in WAIT_ACK, write+ack together
    write_bytes(64, 1);
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    check_state("idle_ack");
    rd_req_i = 1'b1; m_tready_i = 1'b1; n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      if (m_tvalid_o) n++;
      tick();
    end
    m_tready_i = 1'b0; rd_req_i = 1'b0; retry_i = 1'b1;
    tick();
    retry_i = 1'b0;
    check("abort_vld", 32'(m_tvalid_o), 32'd0);
    check_state("abort");
    read_pkt(1, 1);
    read_pkt(2, 0);
    s_tvalid_i = 1'b1; s_tdata_i = 8'h5A; s_tlast_i = 1'b1; ack_i = 1'b1;
    check("coinc_rdy", 32'(s_tready_o), 32'd1);
    model_push(8'h5A, 1'b1);
    tick();
    s_tvalid_i = 1'b0; s_tlast_i = 1'b0; ack_i = 1'b0;
    model_ack();
    check_state("coinc");
    read_pkt(0, 0);

    // fill completely, hold without ack
    write_bytes(DEPTH, 0);
    check("full_rdy", 32'(s_tready_o), 32'd0);
    check_state("full");
    read_pkt(2, 1);
    check("full_noack_rdy", 32'(s_tready_o), 32'd0);
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    model_ack();
    check_state("full_ack");
    check("full_ack_rdy", 32'(s_tready_o), 32'd1);
    for (int k = 0; k < 3; k++) read_pkt(0, 1);

    // pointer wrap with interleaved acks and occasional retries
    for (int k = 0; k < 20; k++) begin
      write_bytes(300, 1);
      if (k % 5 == 3) read_pkt(1, 1);
      if (k >= 1) read_pkt((k % 7 == 5) ? 3 : 0, 1);
    end
    read_pkt(0, 0);
    check_state("wrap_end");

`ifdef USB_BULK_IN_FLUSH_EN
    write_bytes(5, 0);
    n = 0;
    while (!has_data_o && n < 40) begin tick(); n++; end
    check("flush_lat", 32'(n >= 17 && n <= 18), 32'd1);
    exp_q[exp_q.size() - 1][8] = 1'b1;
    mpkts++; mpcnt = 0;
    check_state("flush");
    read_pkt(0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
